// File: rtl/zone_sdi_tx_pkg.sv
// minimiled_pkg: shared MiniLED zone constants and reader FSM encoding
package minimiled_pkg;
  localparam int ZONE_AW = 9;
  localparam int GRAY_W = 8;
  localparam int ZONES_DEF = 360;
  localparam int GROUP_DEF = 24;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, LATCH, DONE} state_t;
endpackage

// File: rtl/zone_sdi_tx_if.sv
// zone_sdi_tx_if: buffer_360 read port plus DCLK/SDI/LE driver-chain pins
interface zone_sdi_tx_if;
  import minimiled_pkg::*;
  logic rd_buf_en;
  logic [ZONE_AW-1:0] array_map;
  logic [GRAY_W-1:0] gray_data;
  logic DCLK;
  logic SDI;
  logic LE;
  modport master(output rd_buf_en, array_map, DCLK, SDI, LE, input gray_data);
  modport slave(input rd_buf_en, array_map, DCLK, SDI, LE, output gray_data);
endinterface

// File: rtl/zone_sdi_tx_shifter.sv
// sdi_bit_shifter: shifts one word MSB first, SDI held over a full DCLK period
module sdi_bit_shifter #(
  parameter int WORD_W = 16,
  parameter int DCLK_DIV = 4
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              dclk,
  output logic              sdi,
  output logic              word_done
);
  localparam int PW = $clog2(DCLK_DIV);
  localparam int BW = $clog2(WORD_W);
  localparam logic [PW-1:0] PH_LAST = PW'(DCLK_DIV - 1);
  localparam logic [PW-1:0] PH_RISE = PW'(DCLK_DIV / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(WORD_W - 1);
  logic [WORD_W-1:0] sh;
  logic [BW-1:0] bit_cnt;
  logic [PW-1:0] ph;
  logic active;
  assign word_done = active && bit_cnt == '0 && ph == PH_LAST;
  // Phase counter drives DCLK low then high; the next bit is presented as DCLK falls
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      sh <= '0;
      bit_cnt <= '0;
      ph <= '0;
      active <= 1'b0;
      dclk <= 1'b0;
      sdi <= 1'b0;
    end else if (load) begin
      sh <= {word[WORD_W-2:0], 1'b0};
      sdi <= word[WORD_W-1];
      bit_cnt <= B_LAST;
      ph <= '0;
      active <= 1'b1;
      dclk <= 1'b0;
    end else if (active) begin
      ph <= ph == PH_LAST ? '0 : ph + 1'b1;
      dclk <= ph != PH_LAST && ph >= PH_RISE;
      if (ph == PH_LAST) begin
        sh <= {sh[WORD_W-2:0], 1'b0};
        sdi <= bit_cnt != '0 && sh[WORD_W-1];
        bit_cnt <= bit_cnt - 1'b1;
        active <= bit_cnt != '0;
      end
    end
  end
endmodule

// File: rtl/zone_sdi_tx.sv
// zone_sdi_tx: reads per-zone gray values from buffer_360 and serialises them as DCLK/SDI/LE frames
module zone_sdi_tx import minimiled_pkg::*; #(
  parameter int ZONES = ZONES_DEF,
  parameter int GROUP = GROUP_DEF,
  parameter int DCLK_DIV = 4,
  parameter int LE_CYC = 4,
  parameter int WORD_W = 16
) (
  input  logic         I_clk,
  input  logic         I_rst,
  input  logic         I_start,
  zone_sdi_tx_if.master bus,
  output logic         O_busy,
  output logic         O_done
);
  localparam int GW = GROUP > 1 ? $clog2(GROUP) : 1;
  localparam int LW = LE_CYC > 1 ? $clog2(LE_CYC) : 1;
  localparam logic [GW-1:0] G_LAST = GW'(GROUP - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LE_CYC - 1);
  localparam logic [ZONE_AW-1:0] Z_LAST = ZONE_AW'(ZONES - 1);
  if (ZONES % GROUP != 0 || DCLK_DIV < 2 || DCLK_DIV % 2 != 0 || WORD_W != 2 * GRAY_W) begin : g_bad
    $error("zone_sdi_tx: illegal parameter combination");
  end
  state_t st;
  logic [ZONE_AW-1:0] zone;
  logic [ZONE_AW-1:0] zone_nx;
  logic [GW-1:0] gc;
  logic [LW-1:0] lc;
  logic word_done;
  assign zone_nx = zone + 1'b1;
  sdi_bit_shifter #(.WORD_W(WORD_W), .DCLK_DIV(DCLK_DIV)) u_shift (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .load(st == WAIT),
    .word({bus.gray_data, bus.gray_data}),
    .dclk(bus.DCLK),
    .sdi(bus.SDI),
    .word_done(word_done)
  );
  // Frame sequencer: fetch a zone, shift it, latch after each group, pulse done at frame end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      st <= IDLE;
      zone <= '0;
      gc <= '0;
      lc <= '0;
      bus.rd_buf_en <= 1'b0;
      bus.array_map <= '0;
      bus.LE <= 1'b0;
      O_busy <= 1'b0;
      O_done <= 1'b0;
    end else begin
      case (st)
        IDLE: if (I_start) begin
          st <= FETCH;
          zone <= '0;
          gc <= '0;
          bus.rd_buf_en <= 1'b1;
          bus.array_map <= '0;
          O_busy <= 1'b1;
        end
        FETCH: begin
          st <= WAIT;
          bus.rd_buf_en <= 1'b0;
        end
        WAIT: st <= SHIFT;
        SHIFT: if (word_done) begin
          if (gc == G_LAST) begin
            st <= LATCH;
            lc <= '0;
            bus.LE <= 1'b1;
          end else begin
            st <= FETCH;
            zone <= zone_nx;
            gc <= gc + 1'b1;
            bus.rd_buf_en <= 1'b1;
            bus.array_map <= zone_nx;
          end
        end
        LATCH: if (lc == L_LAST) begin
          bus.LE <= 1'b0;
          gc <= '0;
          if (zone == Z_LAST) begin
            st <= DONE;
            O_busy <= 1'b0;
            O_done <= 1'b1;
          end else begin
            st <= FETCH;
            zone <= zone_nx;
            bus.rd_buf_en <= 1'b1;
            bus.array_map <= zone_nx;
          end
        end else lc <= lc + 1'b1;
        DONE: begin
          st <= IDLE;
          O_done <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zone_sdi_tx.sv
// tb_zone_sdi_tx: directed frame checks on default and reduced-size zone_sdi_tx instances
module tb_zone_sdi_tx;
  typedef struct {
    int  inst;
    int  mode;
    int  len;
    int  nle;
    int  lelen;
    int  nw;
    int  grp;
    bit  ign;
  } row_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [2];
  logic busy [2];
  logic done [2];
  logic rd [2];
  logic dclk [2];
  logic sdi [2];
  logic le [2];
  logic [8:0] am [2];
  int mode = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdc [2], aerr [2], wc [2], bn [2], stab [2], shi [2], dh [2], dhb [2];
  int lr [2], dpb [2], lel [2], lec [2], leb [2], tf [2], td [2];
  int lelen_a [2][16];
  int leat [2][16];
  logic [15:0] sh [2];
  logic [15:0] wd [2][360];
  bit pd [2], ps [2];
  row_t tbl [4];
  always #5 clk = ~clk;
  zone_sdi_tx_if bus0();
  zone_sdi_tx_if bus1();
  zone_sdi_tx u0 (.I_clk(clk), .I_rst(rst), .I_start(start[0]), .bus(bus0), .O_busy(busy[0]), .O_done(done[0]));
  zone_sdi_tx #(.ZONES(4), .GROUP(2), .DCLK_DIV(2), .LE_CYC(1)) u1 (
    .I_clk(clk), .I_rst(rst), .I_start(start[1]), .bus(bus1), .O_busy(busy[1]), .O_done(done[1]));
  assign rd[0] = bus0.rd_buf_en;
  assign rd[1] = bus1.rd_buf_en;
  assign am[0] = bus0.array_map;
  assign am[1] = bus1.array_map;
  assign dclk[0] = bus0.DCLK;
  assign dclk[1] = bus1.DCLK;
  assign sdi[0] = bus0.SDI;
  assign sdi[1] = bus1.SDI;
  assign le[0] = bus0.LE;
  assign le[1] = bus1.LE;
  function automatic logic [7:0] gval(logic [8:0] a);
    return mode == 0 ? a[7:0] : mode == 1 ? 8'hFF : 8'h00;
  endfunction
  function automatic logic [15:0] exp_word(int m, int z);
    logic [7:0] b;
    b = m == 0 ? z[7:0] : m == 1 ? 8'hFF : 8'h00;
    return {b, b};
  endfunction
  // buffer_360 read port: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus0.rd_buf_en) bus0.gray_data <= gval(bus0.array_map);
    if (bus1.rd_buf_en) bus1.gray_data <= gval(bus1.array_map);
  end
  // Pin monitor: addresses, captured words, DCLK shape, SDI stability, LE pulses, frame timing
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (start[k] && !busy[k] && !done[k] && !rst) begin
        rdc[k] = 0; aerr[k] = 0; wc[k] = 0; bn[k] = 0; stab[k] = 0; shi[k] = 0; dh[k] = 0;
        dhb[k] = 0; dpb[k] = 0; lel[k] = 0; lec[k] = 0; leb[k] = 0; tf[k] = -1; td[k] = -1;
      end
      if (rd[k]) begin
        if (rdc[k] == 0) tf[k] = cyc;
        if (int'(am[k]) != rdc[k]) aerr[k]++;
        rdc[k]++;
      end
      if (dclk[k] && !pd[k]) begin
        if (bn[k] != 0 && cyc - lr[k] != (k == 0 ? 4 : 2)) dpb[k]++;
        lr[k] = cyc;
        sh[k] = {sh[k][14:0], sdi[k]};
        bn[k]++;
        if (bn[k] == 16) begin
          if (wc[k] < 360) wd[k][wc[k]] = sh[k];
          wc[k]++;
          bn[k] = 0;
        end
      end
      if (dclk[k] && pd[k] && sdi[k] != ps[k]) stab[k]++;
      if (dclk[k]) dh[k]++;
      else if (pd[k]) begin
        if (dh[k] != (k == 0 ? 2 : 1)) dhb[k]++;
        dh[k] = 0;
      end
      if (sdi[k]) shi[k]++;
      if (le[k] && (dclk[k] || sdi[k])) leb[k]++;
      if (le[k]) lel[k]++;
      else if (lel[k] > 0) begin
        if (lec[k] < 16) begin
          lelen_a[k][lec[k]] = lel[k];
          leat[k][lec[k]] = wc[k];
        end
        lec[k]++;
        lel[k] = 0;
      end
      if (done[k]) td[k] = cyc;
      pd[k] = dclk[k];
      ps[k] = sdi[k];
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  initial begin
    row_t r;
    int n;
    tbl[0] = '{0, 0, 23821, 15, 4, 360, 24, 1'b1};
    tbl[1] = '{0, 1, 23821, 15, 4, 360, 24, 1'b0};
    tbl[2] = '{1, 0, 139, 2, 1, 4, 2, 1'b0};
    tbl[3] = '{1, 2, 139, 2, 1, 4, 2, 1'b0};
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 2; k++)
      check($sformatf("reset_outputs%0d", k), {rd[k], am[k], dclk[k], sdi[k], le[k], busy[k], done[k]}, 0);
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      r = tbl[i];
      mode = r.mode;
      start[r.inst] = 1'b1;
      step();
      start[r.inst] = 1'b0;
      check($sformatf("busy_on_start%0d", i), busy[r.inst], 1);
      n = 0;
      while (!done[r.inst] && n < 30000) begin
        if (r.ign && (n == 9 || n == 4999)) start[r.inst] = 1'b1;
        step();
        start[r.inst] = 1'b0;
        n++;
      end
      check($sformatf("done_seen%0d", i), done[r.inst], 1);
      if (r.ign) start[r.inst] = 1'b1;
      step();
      start[r.inst] = 1'b0;
      check($sformatf("done_single%0d", i), {done[r.inst], busy[r.inst]}, 0);
      check($sformatf("frame_len%0d", i), td[r.inst] - tf[r.inst] + 1, r.len);
      check($sformatf("rd_count%0d", i), rdc[r.inst], r.nw);
      check($sformatf("addr_order%0d", i), aerr[r.inst], 0);
      check($sformatf("word_count%0d", i), wc[r.inst], r.nw);
      for (int z = 0; z < r.nw; z++)
        check($sformatf("word%0d_z%0d", i, z), wd[r.inst][z], exp_word(r.mode, z));
      check($sformatf("le_count%0d", i), lec[r.inst], r.nle);
      for (int j = 0; j < r.nle && j < 16; j++) begin
        check($sformatf("le_len%0d_%0d", i, j), lelen_a[r.inst][j], r.lelen);
        check($sformatf("le_pos%0d_%0d", i, j), leat[r.inst][j], (j + 1) * r.grp);
      end
      check($sformatf("sdi_stable%0d", i), stab[r.inst], 0);
      check($sformatf("dclk_high%0d", i), dhb[r.inst], 0);
      check($sformatf("dclk_period%0d", i), dpb[r.inst], 0);
      check($sformatf("le_quiet_pins%0d", i), leb[r.inst], 0);
      if (r.mode == 2) check($sformatf("sdi_zero%0d", i), shi[r.inst], 0);
    end
    mode = 0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n = 0;
    while (!(wc[0] == 30 && bn[0] == 5) && n < 5000) begin
      step();
      n++;
    end
    check("reach_zone30", wc[0], 30);
    rst = 1'b1;
    step();
    check("midframe_reset", {rd[0], am[0], dclk[0], sdi[0], le[0], busy[0], done[0]}, 0);
    rst = 1'b0;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    n = 0;
    while (lec[0] == 0 && n < 3000) begin
      step();
      n++;
    end
    check("restart_le_seen", lec[0], 1);
    check("restart_le_pos", leat[0][0], 24);
    check("restart_addr", aerr[0], 0);
    check("restart_first_words", {wd[0][0], wd[0][23]}, {16'h0000, 16'h1717});
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
